range_counter: RTL and testbench

Parametrised bounded up/down counter: next generation of the team's MIN..MAX counter. Adds programmable step, parallel load, three boundary modes (wrap, saturate, bounce) and a registered terminal-count pulse. Serves as the general-purpose sequencer/timebase for datapath control and display-scan logic in the project.

---
 rtl/counter_pkg.sv | 10 +
 rtl/range_prescaler.sv | 36 +++
 rtl/range_counter.sv | 167 ++++++++++++++++
 tb/tb_range_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for range_counter: boundary mode encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_t;

endpackage

// File: rtl/range_prescaler.sv
// Enabled-cycle prescaler for range_counter: tick once every PRESCALE enabled cycles.
// Only instantiated when RANGE_COUNTER_PRESCALE_EN is defined.
module range_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_r;

  // Tick is combinational so the step lands on the same edge as the terminal enabled cycle.
  assign tick = enable & (cnt_r == LAST);

  // Enabled-cycle counter; clear (load) restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {PW{1'b0}};
    end else if (clear) begin
      cnt_r <= {PW{1'b0}};
    end else if (tick) begin
      cnt_r <= {PW{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + PW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/range_counter.sv
// Bounded MIN..MAX up/down counter with step, clamped load, WRAP/SAT/BOUNCE modes and a registered tc.
// Optional step prescaler: define RANGE_COUNTER_PRESCALE_EN.
module range_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MIN      = 3,
  parameter int MAX      = 27,
  parameter int STEP     = 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc
);

  localparam int               XW         = WIDTH + 1;
  localparam logic [XW-1:0]    MIN_X      = XW'(MIN);
  localparam logic [XW-1:0]    MAX_X      = XW'(MAX);
  localparam logic [XW-1:0]    STEP_X     = XW'(STEP);
  localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MAX_BACK_W = WIDTH'(MAX - STEP);
  localparam logic [WIDTH-1:0] MIN_FWD_W  = WIDTH'(MIN + STEP);

  if (!(MIN >= 0 && MIN < MAX && MAX <= (2 ** WIDTH) - 1 &&
        STEP >= 1 && STEP <= MAX - MIN && PRESCALE >= 2)) begin : g_bad_params
    $error("range_counter: illegal parameter set");
  end

  logic [WIDTH-1:0] count_r, count_n_s, load_clamp_s;
  logic             dir_r, dir_n_s, tc_r, tc_n_s, step_s;
  logic [XW-1:0]    cnt_x_s, up_x_s, dn_x_s;
  logic             over_s, under_s;

`ifdef RANGE_COUNTER_PRESCALE_EN
  logic tick_s;

  range_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (tick_s)
  );

  assign step_s = enable & tick_s;
`else
  assign step_s = enable;
`endif

  // One extra bit so overshoot and borrow are seen explicitly, not lost to binary wrap.
  assign cnt_x_s = {1'b0, count_r};
  assign up_x_s  = cnt_x_s + STEP_X;
  assign dn_x_s  = cnt_x_s - STEP_X;
  assign over_s  = up_x_s > MAX_X;
  assign under_s = dn_x_s[WIDTH] | (dn_x_s < MIN_X);

  // Load value clamp into [MIN, MAX].
  always_comb begin
    if (load_val < MIN_W) begin
      load_clamp_s = MIN_W;
    end else if (load_val > MAX_W) begin
      load_clamp_s = MAX_W;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next-state: load > step > hold, boundary handling per mode.
  always_comb begin
    count_n_s = count_r;
    dir_n_s   = dir_r;
    tc_n_s    = 1'b0;
    if (load) begin
      count_n_s = load_clamp_s;
    end else if (step_s) begin
      case (mode)
        MODE_SAT: begin
          if (up) begin
            if (over_s) begin
              count_n_s = MAX_W;
              tc_n_s    = (count_r != MAX_W);
            end else begin
              count_n_s = up_x_s[WIDTH-1:0];
            end
          end else begin
            if (under_s) begin
              count_n_s = MIN_W;
              tc_n_s    = (count_r != MIN_W);
            end else begin
              count_n_s = dn_x_s[WIDTH-1:0];
            end
          end
        end
        MODE_BOUNCE: begin
          if (dir_r) begin
            if (count_r == MAX_W) begin
              dir_n_s   = 1'b0;
              count_n_s = MAX_BACK_W;
              tc_n_s    = 1'b1;
            end else if (over_s) begin
              count_n_s = MAX_W;
            end else begin
              count_n_s = up_x_s[WIDTH-1:0];
            end
          end else begin
            if (count_r == MIN_W) begin
              dir_n_s   = 1'b1;
              count_n_s = MIN_FWD_W;
              tc_n_s    = 1'b1;
            end else if (under_s) begin
              count_n_s = MIN_W;
            end else begin
              count_n_s = dn_x_s[WIDTH-1:0];
            end
          end
        end
        default: begin
          // WRAP, and reserved encoding 3 behaves the same.
          if (up) begin
            if (over_s) begin
              count_n_s = MIN_W;
              tc_n_s    = 1'b1;
            end else begin
              count_n_s = up_x_s[WIDTH-1:0];
            end
          end else begin
            if (under_s) begin
              count_n_s = MAX_W;
              tc_n_s    = 1'b1;
            end else begin
              count_n_s = dn_x_s[WIDTH-1:0];
            end
          end
        end
      endcase
    end else begin
      count_n_s = count_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= MIN_W;
      dir_r   <= 1'b1;
      tc_r    <= 1'b0;
    end else begin
      count_r <= count_n_s;
      dir_r   <= dir_n_s;
      tc_r    <= tc_n_s;
    end
  end

  assign count = count_r;
  assign dir   = dir_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: STEP=1 and STEP=5 instances share stimulus, checked
// against a behavioural model. Prescale model follows RANGE_COUNTER_PRESCALE_EN.
module tb_range_counter;

  localparam int WIDTH    = 5;
  localparam int MIN      = 3;
  localparam int MAX      = 27;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             up = 1'b0;
  logic             load = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count0, count1;
  logic             dir0, dir1, tc0, tc1;

  always #5 clk = ~clk;

  range_counter #(.WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .STEP(1), .PRESCALE(PRESCALE)) dut_s1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .count(count0), .dir(dir0), .tc(tc0)
  );

  range_counter #(.WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .STEP(5), .PRESCALE(PRESCALE)) dut_s5 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .mode(mode), .load(load),
    .load_val(load_val), .count(count1), .dir(dir1), .tc(tc1)
  );

  typedef struct packed {
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic             d0;
    logic             d1;
    logic             t0;
    logic             t1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_c[2];
  bit   m_d[2];
  bit   m_t[2];
  int   m_pre;
  int   steps[2] = '{1, 5};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written from the counting rules with plain integers.
  task automatic model_next(input int s, input int c, input bit d, input int md, input bit u,
                            input bit ld, input int lv, input bit st,
                            output int nc, output bit nd, output bit nt);
    nc = c; nd = d; nt = 1'b0;
    if (ld) begin
      nc = (lv < MIN) ? MIN : ((lv > MAX) ? MAX : lv);
    end else if (st) begin
      if (md == 2) begin
        if (d && c == MAX) begin
          nd = 1'b0; nc = MAX - s; nt = 1'b1;
        end else if (!d && c == MIN) begin
          nd = 1'b1; nc = MIN + s; nt = 1'b1;
        end else if (d) begin
          nc = (c + s > MAX) ? MAX : c + s;
        end else begin
          nc = (c - s < MIN) ? MIN : c - s;
        end
      end else if (md == 1) begin
        if (u) begin
          nc = (c + s > MAX) ? MAX : c + s;
          nt = (c + s > MAX) && (c != MAX);
        end else begin
          nc = (c - s < MIN) ? MIN : c - s;
          nt = (c - s < MIN) && (c != MIN);
        end
      end else begin
        if (u) begin
          nt = (c + s > MAX);
          nc = nt ? MIN : c + s;
        end else begin
          nt = (c - s < MIN);
          nc = nt ? MAX : c - s;
        end
      end
    end
  endtask

  task automatic drive(input bit en, input bit u, input int md, input bit ld, input int lv);
    bit   st;
    int   nc;
    bit   nd, nt;
    exp_t e;
    @(negedge clk);
    enable = en; up = u; mode = md[1:0]; load = ld; load_val = lv[WIDTH-1:0];
`ifdef RANGE_COUNTER_PRESCALE_EN
    st = en && !ld && (m_pre == PRESCALE - 1);
    if (ld) m_pre = 0;
    else if (en) m_pre = (m_pre == PRESCALE - 1) ? 0 : m_pre + 1;
`else
    st = en && !ld;
`endif
    for (int k = 0; k < 2; k++) begin
      model_next(steps[k], m_c[k], m_d[k], md, u, ld, lv, st, nc, nd, nt);
      m_c[k] = nc; m_d[k] = nd; m_t[k] = nt;
    end
    e.c0 = WIDTH'(m_c[0]); e.c1 = WIDTH'(m_c[1]);
    e.d0 = m_d[0]; e.d1 = m_d[1]; e.t0 = m_t[0]; e.t1 = m_t[1];
    sbq.push_back(e);
  endtask

  task automatic reset_model();
    m_c = '{MIN, MIN}; m_d = '{1'b1, 1'b1}; m_t = '{1'b0, 1'b0}; m_pre = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_count_s1"}, int'(count0), MIN);
    chk({tag, "_dir_s1"},   int'(dir0),   1);
    chk({tag, "_tc_s1"},    int'(tc0),    0);
    chk({tag, "_count_s5"}, int'(count1), MIN);
    chk({tag, "_dir_s5"},   int'(dir1),   1);
    chk({tag, "_tc_s5"},    int'(tc1),    0);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next clock.
  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; load = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_state("async_rst");
    reset_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: compare each presented cycle result against the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("count_s1", int'(count0), int'(mon_e.c0));
        chk("dir_s1",   int'(dir0),   int'(mon_e.d0));
        chk("tc_s1",    int'(tc0),    int'(mon_e.t0));
        chk("count_s5", int'(count1), int'(mon_e.c1));
        chk("dir_s5",   int'(dir1),   int'(mon_e.d1));
        chk("tc_s5",    int'(tc1),    int'(mon_e.t1));
      end
    end
  end

  initial begin
    int pat[5] = '{1, 1, 0, 1, 1};
    reset_model();
    repeat (2) @(negedge clk);
    check_reset_state("power_on_rst");
    reset = 1'b1;

    // WRAP up through MAX and back to MIN.
    repeat (26) drive(1'b1, 1'b1, 0, 1'b0, 0);

    // SAT down at MIN, then clamped loads.
    drive(1'b0, 1'b0, 1, 1'b1, 3);
    repeat (5) drive(1'b1, 1'b0, 1, 1'b0, 0);
    drive(1'b0, 1'b0, 1, 1'b1, 30);
    drive(1'b0, 1'b0, 1, 1'b1, 1);
    drive(1'b0, 1'b0, 1, 1'b0, 0);

    // BOUNCE with the up input toggling randomly.
    drive(1'b0, 1'b0, 2, 1'b1, 3);
    repeat (24) drive(1'b1, 1'($urandom_range(0, 1)), 2, 1'b0, 0);

    // Load wins over a simultaneous step.
    drive(1'b0, 1'b1, 0, 1'b1, 20);
    drive(1'b1, 1'b1, 0, 1'b1, 10);
    repeat (3) drive(1'b1, 1'b1, 0, 1'b0, 0);

    // Gapped enable pattern.
    drive(1'b0, 1'b1, 0, 1'b1, 5);
    foreach (pat[i]) drive(pat[i] != 0, 1'b1, 0, 1'b0, 0);
    drive(1'b0, 1'b1, 0, 1'b0, 0);

    // Reach dir=0 in BOUNCE, park at 15, then reset mid-count.
    drive(1'b0, 1'b1, 2, 1'b1, 27);
    repeat (4) drive(1'b1, 1'b1, 2, 1'b0, 0);
    drive(1'b0, 1'b0, 2, 1'b1, 15);
    do_reset();

    // Random traffic, including reserved mode 3 and out-of-range loads.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      drive(($urandom % 4) != 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom % 10) == 0, int'($urandom_range(0, 31)));
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
